requant_mul_arbiter: RTL

//  Shares one MultiplyByQuantizedMultiplier* requant pipeline (fixed latency, non-stallable) among
//  NUM_REQ requesters (e.g. per-lane conv/add/exp post-processing units). Round-robin arbitrates

---
 rtl/requant_mul_arbiter_if.sv | 42 ++++
 rtl/requant_mul_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/requant_mul_arbiter_if.sv
// Bundle between the requesters, the shared requant pipeline and the result consumer.
// Every valid/ready pair transfers on a rising edge where both are high; valid never waits on ready.
interface requant_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_x;
  logic [NUM_REQ*32-1:0] req_qm;
  logic [NUM_REQ*32-1:0] req_shift;

  logic                  mul_in_valid;
  logic [31:0]           mul_x;
  logic [31:0]           mul_qm;
  logic [31:0]           mul_shift;
  logic                  mul_out_valid;
  logic [31:0]           mul_result;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_data;

  modport slave (
    input  req_valid, req_x, req_qm, req_shift,
    input  mul_out_valid, mul_result,
    input  rsp_ready,
    output req_ready,
    output mul_in_valid, mul_x, mul_qm, mul_shift,
    output rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_x, req_qm, req_shift,
    output mul_out_valid, mul_result,
    output rsp_ready,
    input  req_ready,
    input  mul_in_valid, mul_x, mul_qm, mul_shift,
    input  rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/requant_mul_arbiter.sv
// Round-robin front end for one fixed-latency requant pipeline: tags each op with its requester,
// re-associates returning results in order and buffers them behind a credit check.
module requant_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IDW        = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int MUL_LAT    = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  requant_mul_arbiter_if.slave  bus,
  output logic                  busy_o,
  output logic                  err_orphan_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < MUL_LAT + 1) begin : g_depth_check
    $error("FIFO_DEPTH too small for back-to-back issue");
  end
  if ((1 << AW) != FIFO_DEPTH) begin : g_pow2_check
    $error("FIFO_DEPTH must be a power of 2");
  end

  logic [31:0]       lane_x     [NUM_REQ];
  logic [31:0]       lane_qm    [NUM_REQ];
  logic [31:0]       lane_shift [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_x[g]     = bus.req_x[32*g +: 32];
    assign lane_qm[g]    = bus.req_qm[32*g +: 32];
    assign lane_shift[g] = bus.req_shift[32*g +: 32];
  end

  logic              run_q;
  logic [IDW-1:0]    rr_q, rr_d;
  logic              mul_vld_q, mul_vld_d;
  logic [31:0]       mul_x_q, mul_x_d;
  logic [31:0]       mul_qm_q, mul_qm_d;
  logic [31:0]       mul_shift_q, mul_shift_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [AW-1:0]     idq_wr_q, idq_wr_d;
  logic [AW-1:0]     idq_rd_q, idq_rd_d;
  logic [CW-1:0]     rf_cnt_q, rf_cnt_d;
  logic [AW-1:0]     rf_wr_q, rf_wr_d;
  logic [AW-1:0]     rf_rd_q, rf_rd_d;
  logic              orphan_q, orphan_d;

  logic [IDW-1:0]    idq_mem [FIFO_DEPTH];
  logic [IDW+31:0]   rf_mem  [FIFO_DEPTH];

  logic              pick_found;
  logic [IDW-1:0]    pick_idx;
  logic [CW:0]       occupancy;
  logic              credit_ok;
  logic              xfer;
  logic              ret_push;
  logic              rsp_pop;
  logic              rsp_vld;
  logic [IDW+31:0]   rsp_head;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      idx = sum[IDW-1:0];
      if (!pick_found && bus.req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  // Ops in the pipeline plus buffered results can never exceed the result buffer.
  assign occupancy = {1'b0, inflight_q} + {1'b0, rf_cnt_q};
  assign credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);
  assign xfer      = run_q && pick_found && credit_ok;

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[pick_idx] = 1'b1;
  end

  assign ret_push = bus.mul_out_valid && (inflight_q != '0);
  assign rsp_vld  = rf_cnt_q != '0;
  assign rsp_pop  = rsp_vld && bus.rsp_ready;
  assign rsp_head = rf_mem[rf_rd_q];

  always_comb begin
    rr_d        = rr_q;
    mul_vld_d   = xfer;
    mul_x_d     = mul_x_q;
    mul_qm_d    = mul_qm_q;
    mul_shift_d = mul_shift_q;
    inflight_d  = inflight_q;
    idq_wr_d    = idq_wr_q;
    idq_rd_d    = idq_rd_q;
    rf_cnt_d    = rf_cnt_q;
    rf_wr_d     = rf_wr_q;
    rf_rd_d     = rf_rd_q;
    orphan_d    = orphan_q;

    if (xfer) begin
      rr_d        = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      mul_x_d     = lane_x[pick_idx];
      mul_qm_d    = lane_qm[pick_idx];
      mul_shift_d = lane_shift[pick_idx];
      idq_wr_d    = idq_wr_q + 1'b1;
    end

    if (ret_push) begin
      idq_rd_d = idq_rd_q + 1'b1;
      rf_wr_d  = rf_wr_q + 1'b1;
    end
    if (bus.mul_out_valid && (inflight_q == '0)) orphan_d = 1'b1;

    case ({xfer, ret_push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    if (rsp_pop) rf_rd_d = rf_rd_q + 1'b1;
    case ({ret_push, rsp_pop})
      2'b10:   rf_cnt_d = rf_cnt_q + 1'b1;
      2'b01:   rf_cnt_d = rf_cnt_q - 1'b1;
      default: rf_cnt_d = rf_cnt_q;
    endcase
  end

  // run_q keeps req_ready low while reset is asserted, whatever req_valid does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      rr_q        <= '0;
      mul_vld_q   <= 1'b0;
      mul_x_q     <= '0;
      mul_qm_q    <= '0;
      mul_shift_q <= '0;
      inflight_q  <= '0;
      idq_wr_q    <= '0;
      idq_rd_q    <= '0;
      rf_cnt_q    <= '0;
      rf_wr_q     <= '0;
      rf_rd_q     <= '0;
      orphan_q    <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      rr_q        <= rr_d;
      mul_vld_q   <= mul_vld_d;
      mul_x_q     <= mul_x_d;
      mul_qm_q    <= mul_qm_d;
      mul_shift_q <= mul_shift_d;
      inflight_q  <= inflight_d;
      idq_wr_q    <= idq_wr_d;
      idq_rd_q    <= idq_rd_d;
      rf_cnt_q    <= rf_cnt_d;
      rf_wr_q     <= rf_wr_d;
      rf_rd_q     <= rf_rd_d;
      orphan_q    <= orphan_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer)     idq_mem[idq_wr_q] <= pick_idx;
    if (ret_push) rf_mem[rf_wr_q]   <= {idq_mem[idq_rd_q], bus.mul_result};
  end

  assign bus.mul_in_valid = mul_vld_q;
  assign bus.mul_x        = mul_x_q;
  assign bus.mul_qm       = mul_qm_q;
  assign bus.mul_shift    = mul_shift_q;

  // Head is masked while empty so the result port reads zero rather than stale storage.
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_id    = rsp_vld ? rsp_head[IDW+31:32] : '0;
  assign bus.rsp_data  = rsp_vld ? rsp_head[31:0] : '0;

  assign busy_o       = (inflight_q != '0) || rsp_vld;
  assign err_orphan_o = orphan_q;
endmodule
